// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN process network: token width, default
// channel depth and the token type passed between process stages.
package kpn_pkg;

    localparam int KPN_TOKEN_W    = 32;
    localparam int KPN_FIFO_DEPTH = 8;

    typedef logic [KPN_TOKEN_W-1:0] kpn_token_t;

endpackage : kpn_pkg

// File: rtl/kpn_fifo_mem.sv
// Dual-port register array for the KPN channel: one synchronous write port
// and one registered read port whose register is the channel's data_out.
module kpn_fifo_mem
    import kpn_pkg::*;
#(
    parameter int WIDTH = KPN_TOKEN_W,
    parameter int DEPTH = KPN_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : kpn_fifo_mem

// File: rtl/kpn_fifo_channel.sv
// Bounded blocking FIFO channel between KPN producer and consumer processes,
// with sticky overflow/underflow flags recording protocol violations.
module kpn_fifo_channel
    import kpn_pkg::*;
#(
    parameter int WIDTH = KPN_TOKEN_W,
    parameter int DEPTH = KPN_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     full,
    input  logic                     rd,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc;
    logic          rd_acc;

    // Flags come straight from the registered pointers, so they are glitch-free.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count  = wr_ptr_q - rd_ptr_q;
    assign wr_acc = wr && !full;
    assign rd_acc = rd && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q | (wr && full);
        underflow_d = underflow_q | (rd && empty);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    kpn_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (data_out)
    );

endmodule : kpn_fifo_channel

// File: doc/kpn_fifo_channel.md
# kpn_fifo_channel

Bounded FIFO channel that links KPN process modules such as the multiplier and adder stages. It is the responder side of the process `rd`/`wr` strobes. A producer process pushes 32-bit tokens with `wr`, and a consumer process pops them with `rd`. The channel implements blocking-write/blocking-read semantics through `full`/`empty` and records protocol violations in sticky flags.

## Interface
Parameters:
- `WIDTH`, 32: token width; matches the 32-bit multiplier product.
- `DEPTH`, 8: number of token slots; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr`  in  1  producer write strobe; pushes `data_in` at the edge.
- `data_in`  in  WIDTH  token to push.
- `full`  out  1  no free slot; the producer must hold off.
- `rd`  in  1  consumer read strobe; pops the head token at the edge.
- `data_out`  out  WIDTH  last popped token, registered.
- `empty`  out  1  no stored token; the consumer must hold off.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set by any write attempted while `full`.
- `underflow`  out  1  sticky; set by any read attempted while `empty`.

## Operation
- Storage is a circular buffer of DEPTH entries.
- Write and read pointers are each $clog2(DEPTH)+1 bits. The MSB is the wrap bit.
- Empty: pointers are equal.
- Full: index bits are equal and wrap bits differ.
- Accepted write (`wr && !full`, sampled pre-edge):
  - mem[wr_ptr] <= `data_in`.
  - wr_ptr increments and wraps naturally at 2*DEPTH.
- Accepted read (`rd && !empty`, sampled pre-edge):
  - `data_out` <= mem[rd_ptr].
  - rd_ptr increments.
- Rejected write: storage and pointers are unchanged; `overflow` <= 1.
- Rejected read: `data_out` holds its value; pointers are unchanged; `underflow` <= 1.
- Simultaneous `rd` and `wr`:
  - Each strobe is judged only on pre-edge flags.
  - When full: the read is accepted and the write is rejected. There is no pass-through.
  - When empty: the write is accepted and the read is rejected. There is no bypass; `data_out` is unchanged.
  - Otherwise: both are accepted and `count` is unchanged.
- `count` = wr_ptr - rd_ptr, modulo 2*DEPTH. It is +1 on a lone accepted write and -1 on a lone accepted read.
- `overflow` and `underflow` clear only on reset.
- No arithmetic is performed on tokens; they are passed through bit-exact.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream):
  - `data_out`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `underflow`=0.
  - Pointers are 0.
  - Storage contents are don't-care.
- Reset mid-operation: all stored tokens are discarded immediately; outputs take their reset values while `reset_n` is low.
- Write-to-read latency:
  - A token written at edge N sets `empty`=0 after edge N.
  - It is popped no earlier than edge N+1.
  - `data_out` is valid after the popping edge, so read latency is 1 cycle.
- `full`, `empty` and `count` are registered or derived only from registered pointers. They are glitch-free and valid the cycle after the causing edge.
- Back-to-back: one write and one read may be accepted every cycle indefinitely with no bubbles.

## Structure
- Shared package `kpn_pkg`:
  - `KPN_TOKEN_W`=32 and `KPN_FIFO_DEPTH`=8, which supply the parameter defaults.
  - A `kpn_token_t` typedef, logic [KPN_TOKEN_W-1:0].
- Sub-module `kpn_fifo_mem`: simple dual-port register array with one synchronous write port and one registered read port.
- The parent holds the pointers, flags and `count`.

## Test plan
- Reset, then idle 5 cycles: `empty`=1, `full`=0, `count`=0, `data_out`=0, both sticky flags 0.
- Write 0x0000_0006, 0x0000_0F0F, 0xFFFE_0001 on consecutive cycles, then read 3: `data_out` gives the same three values in order, each one cycle after its `rd`; then `empty`=1.
- Fill 8 tokens 1..8, then write 9: `full`=1, `count`=8, `overflow`=1. Draining returns 1..8 with no 9.
- With 8 stored, assert `rd` and `wr`(0xAA) together: `data_out`=1, `count`=8→7, `overflow`=1, 0xAA absent on drain.
- With the channel empty, assert `rd` and `wr`(0x55) together: `underflow`=1, `data_out` unchanged, `count`=1; the next `rd` returns 0x55.
- Run 20 write/read cycles of a streaming counter (wraps pointers twice), then pulse `reset_n` low mid-stream: the outputs match the reset values immediately, and a subsequent write/read of 0x1234 returns 0x1234.
